// File: rtl/demux16_pkg.sv
// Shared widths and bit-position mapping for the 16-bit deserializer.
// DEMUX16_MSB_FIRST_EN selects MSB-first placement; LSB-first when undefined.
package demux16_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned IDX_W  = 4;

    function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
`ifdef DEMUX16_MSB_FIRST_EN
        return IDX_W'(WORD_W - 1) - idx;
`else
        return idx;
`endif
    endfunction

endpackage

// File: rtl/demux16.sv
// Combinational 1-to-16 decoder producing one-hot per-bit write enables.
module demux16
    import demux16_pkg::*;
(
    input  logic [IDX_W-1:0]  sel,
    input  logic              en,
    output logic [WORD_W-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux16_deser.sv
// Serial-to-parallel deserializer with valid/ready on both sides.
// DEMUX16_MSB_FIRST_EN places the first bit of a word in dout[15] instead of dout[0].
module demux16_deser
    import demux16_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              sof,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [IDX_W-1:0]  idx,
    output logic              frame_err
);

    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(WORD_W - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              frame_err_q, frame_err_d;

    logic              accept;
    logic              complete;
    logic [IDX_W-1:0]  pos;
    logic [WORD_W-1:0] we;

    // Only the completing bit stalls; earlier bits of the next word keep flowing.
    assign din_ready = !(dout_valid_q && !dout_ready && (idx_q == IdxLast));
    assign accept    = din_valid && din_ready;
    assign complete  = accept && !sof && (idx_q == IdxLast);
    assign pos       = sof ? bit_pos('0) : bit_pos(idx_q);

    demux16 u_demux16 (
        .sel (pos),
        .en  (accept),
        .we  (we)
    );

    always_comb begin
        for (int i = 0; i < int'(WORD_W); i++) begin
            asm_d[i] = we[i] ? din : asm_q[i];
        end

        idx_d = idx_q;
        if (accept) begin
            idx_d = sof ? IDX_W'(1) : idx_q + IDX_W'(1);
        end

        dout_d       = complete ? asm_d : dout_q;
        dout_valid_d = dout_valid_q;
        if (complete) begin
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        frame_err_d = accept && sof && (idx_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            asm_q        <= RESET_WORD;
            dout_q       <= RESET_WORD;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign idx        = idx_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_demux16_deser.sv
// Directed self-checking bench for demux16_deser; expected words follow DEMUX16_MSB_FIRST_EN.
module tb_demux16_deser;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        din_ready;
    logic        sof;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [3:0]  idx;
    logic        frame_err;

    int checks;
    int errors;

    demux16_deser #(
        .RESET_WORD (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sof        (sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .idx        (idx),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word seen on dout when v is streamed bit 0 first.
    function automatic logic [15:0] exp_word(input logic [15:0] v);
`ifdef DEMUX16_MSB_FIRST_EN
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_bit(input logic b, input logic s);
        din       = b;
        sof       = s;
        din_valid = 1'b1;
        step();
    endtask

    task automatic idle();
        din_valid = 1'b0;
        sof       = 1'b0;
        step();
    endtask

    logic [15:0] w;

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        din        = 1'b1;
        din_valid  = 1'b1;
        sof        = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);

        // Reset with din_valid toggling
        step();
        din_valid = 1'b0;
        step();
        chk("rst_dout", dout, 16'h0000);
        chk("rst_dout_valid", 16'(dout_valid), 16'h0);
        chk("rst_idx", 16'(idx), 16'h0);
        chk("rst_din_ready", 16'(din_ready), 16'h1);
        chk("rst_frame_err", 16'(frame_err), 16'h0);
        rst = 1'b0;
        idle();
        chk("post_rst_idx", 16'(idx), 16'h0);

        // Single word
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) push_bit(w[i], 1'b0);
        chk("single_valid", 16'(dout_valid), 16'h1);
        chk("single_dout", dout, exp_word(16'hA5C3));
        chk("single_idx", 16'(idx), 16'h0);
        idle();
        chk("single_valid_drop", 16'(dout_valid), 16'h0);

        // Back-to-back words, no bubble
        for (int i = 0; i < 32; i++) begin
            if (i == 16) begin
                chk("b2b_valid1", 16'(dout_valid), 16'h1);
                chk("b2b_dout1", dout, exp_word(16'h0001));
            end
            if (i == 17) chk("b2b_valid_gap", 16'(dout_valid), 16'h0);
            w         = (i < 16) ? 16'h0001 : 16'h8000;
            din       = w[i % 16];
            sof       = 1'b0;
            din_valid = 1'b1;
            #1;
            if (din_ready !== 1'b1) chk("b2b_din_ready", 16'(din_ready), 16'h1);
            @(negedge clk);
        end
        chk("b2b_valid2", 16'(dout_valid), 16'h1);
        chk("b2b_dout2", dout, exp_word(16'h8000));
        idle();
        chk("b2b_idle_valid", 16'(dout_valid), 16'h0);

        // Backpressure on the completing bit
        dout_ready = 1'b0;
        w = 16'hBEEF;
        for (int i = 0; i < 16; i++) push_bit(w[i], 1'b0);
        chk("bp_word1", dout, exp_word(16'hBEEF));
        w = 16'h1234;
        for (int i = 0; i < 15; i++) push_bit(w[i], 1'b0);
        chk("bp_idx15", 16'(idx), 16'hF);
        din       = w[15];
        din_valid = 1'b1;
        #1;
        chk("bp_stall_ready", 16'(din_ready), 16'h0);
        @(negedge clk);
        chk("bp_stall_idx", 16'(idx), 16'hF);
        chk("bp_hold_dout", dout, exp_word(16'hBEEF));
        chk("bp_hold_valid", 16'(dout_valid), 16'h1);
        dout_ready = 1'b1;
        #1;
        chk("bp_release_ready", 16'(din_ready), 16'h1);
        @(negedge clk);
        chk("bp_word2", dout, exp_word(16'h1234));
        chk("bp_word2_valid", 16'(dout_valid), 16'h1);
        chk("bp_idx_wrap", 16'(idx), 16'h0);
        idle();
        chk("bp_consumed", 16'(dout_valid), 16'h0);

        // Frame error: sof at idx 7
        for (int i = 0; i < 7; i++) push_bit(1'b0, 1'b0);
        chk("fe_idx7", 16'(idx), 16'h7);
        din_valid = 1'b0;
        sof       = 1'b1;
        step();
        chk("fe_ignored_idx", 16'(idx), 16'h7);
        chk("fe_ignored_err", 16'(frame_err), 16'h0);
        w = 16'h5A5B;
        push_bit(w[0], 1'b1);
        chk("fe_pulse", 16'(frame_err), 16'h1);
        chk("fe_idx1", 16'(idx), 16'h1);
        push_bit(w[1], 1'b0);
        chk("fe_pulse_end", 16'(frame_err), 16'h0);
        for (int i = 2; i < 16; i++) push_bit(w[i], 1'b0);
        chk("fe_word_valid", 16'(dout_valid), 16'h1);
        chk("fe_word", dout, exp_word(16'h5A5B));

        // Reset mid-word with a pending word; sof at idx 0 is legal
        dout_ready = 1'b0;
        push_bit(1'b1, 1'b1);
        chk("sof_idx0_no_err", 16'(frame_err), 16'h0);
        for (int i = 1; i < 9; i++) push_bit(1'b1, 1'b0);
        chk("mid_idx9", 16'(idx), 16'h9);
        chk("mid_pending", 16'(dout_valid), 16'h1);
        rst       = 1'b1;
        din_valid = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_idx", 16'(idx), 16'h0);
        chk("mid_rst_valid", 16'(dout_valid), 16'h0);
        chk("mid_rst_dout", dout, 16'h0000);
        dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_bit(1'b1, 1'b0);
        chk("mid_ffff_valid", 16'(dout_valid), 16'h1);
        chk("mid_ffff", dout, 16'hFFFF);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
